// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
// The ALU decoder imports the ALUOp encodings from here as well.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  // Pure state-derived control fields. The two *_on_ready terms are only
  // requests; the top qualifies them with mem_ready and reset.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write_on_ready;
    logic       reg_write;
    logic       mem_write;
    logic       pc_update_on_ready;
    logic       pc_update;
    logic       branch;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // Loads and stores share the address-calculation state.
  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_controller_output_decode.sv
// Moore output map: turns the current controller state into its control fields.
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Every field defaults to zero so each state only lists what it asserts.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req            = 1'b1;
        ctrl.alu_src_b          = SRCB_FOUR;
        ctrl.result_src         = RESULT_ALU;
        ctrl.ir_write_on_ready  = 1'b1;
        ctrl.pc_update_on_ready = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RESULT_DATA;
        ctrl.reg_write  = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RESULT_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      BEQ: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_update = 1'b1;
      end
      ILLEGAL: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: state register, next-state logic and
// the PCWrite/IRWrite qualification around the Moore output decoder.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       illegal,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp
);

  state_t state;
  ctrl_t  ctrl;

  // State register and transition logic; reset returns to FETCH at once,
  // even from ILLEGAL, which otherwise never exits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          if (is_mem_op(op))     state <= MEMADR;
          else if (op == OP_RTYP) state <= EXECR;
          else if (op == OP_IALU) state <= EXECI;
          else if (op == OP_BEQ)  state <= BEQ;
          else if (op == OP_JAL)  state <= JAL;
          else                    state <= ILLEGAL;
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        JAL:      state <= ALUWB;
        MEMWB:    state <= FETCH;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        ILLEGAL:  state <= ILLEGAL;
        default:  state <= ILLEGAL;
      endcase
    end
  end

  mc_output_decode u_output_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  // Write enables that depend on live inputs; reset masks them so nothing
  // is committed while the controller is held in FETCH.
  always_comb begin
    IRWrite = ctrl.ir_write_on_ready & mem_ready & ~rst;
    PCWrite = (ctrl.pc_update
               | (ctrl.pc_update_on_ready & mem_ready)
               | (ctrl.branch & zero)) & ~rst;
  end

  assign mem_req   = ctrl.mem_req;
  assign AdrSrc    = ctrl.adr_src;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign Branch    = ctrl.branch;
  assign illegal   = ctrl.illegal;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues the expected
// output word for each cycle, the monitor pops and compares on the falling edge.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, Branch, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [15:0] obs;

  // Output word: {mem_req,AdrSrc,IRWrite,RegWrite,MemWrite,PCWrite,Branch,
  //               illegal,ALUSrcA,ALUSrcB,ResultSrc,ALUOp}
  localparam logic [15:0] E_FETCH_WAIT = 16'h8028;
  localparam logic [15:0] E_FETCH_GO   = 16'hA428;
  localparam logic [15:0] E_DECODE     = 16'h0050;
  localparam logic [15:0] E_MEMADR     = 16'h0090;
  localparam logic [15:0] E_MEMREAD    = 16'hC000;
  localparam logic [15:0] E_MEMWRITE   = 16'hC800;
  localparam logic [15:0] E_MEMWB      = 16'h1004;
  localparam logic [15:0] E_ALUWB      = 16'h1000;
  localparam logic [15:0] E_EXECR      = 16'h0082;
  localparam logic [15:0] E_EXECI      = 16'h0092;
  localparam logic [15:0] E_BEQ_TAKEN  = 16'h0681;
  localparam logic [15:0] E_BEQ_NOT    = 16'h0281;
  localparam logic [15:0] E_JAL        = 16'h0460;
  localparam logic [15:0] E_ILLEGAL    = 16'h0100;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTYP = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  multicycle_controller dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .illegal   (illegal),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp)
  );

  assign obs = {mem_req, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, Branch,
                illegal, ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sets this cycle's inputs, queues the word expected for it, then waits
  // until just after the next rising edge.
  task automatic applyStimulus(input logic [6:0] o, input logic z, input logic mr,
                               input logic [15:0] e, input string nm);
    exp_t item;
    op        = o;
    zero      = z;
    mem_ready = mr;
    item.exp  = e;
    item.name = nm;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t item);
    vectors++;
    if (obs !== item.exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", item.name, obs, item.exp);
    end
  endtask

  // Monitor: one expected word is consumed per falling edge while any are queued.
  always @(negedge clk) begin
    exp_t item;
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      checkOutput(item);
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed stimulus.
  initial begin
    exp_t item;
    rst = 1'b1; op = RTYP; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(RTYP, 1'b1, 1'b1, E_FETCH_WAIT, "reset_hold");
    rst = 1'b0;

    // lw, mem_ready tied high: 5 cycles
    applyStimulus(LW, 1'b0, 1'b1, E_FETCH_GO, "lw_fetch");
    applyStimulus(LW, 1'b0, 1'b1, E_DECODE,   "lw_decode");
    applyStimulus(LW, 1'b0, 1'b1, E_MEMADR,   "lw_memadr");
    applyStimulus(LW, 1'b0, 1'b1, E_MEMREAD,  "lw_memread");
    applyStimulus(LW, 1'b0, 1'b1, E_MEMWB,    "lw_memwb");

    // sw with three stalled MEMWRITE cycles; mem_ready low elsewhere is ignored
    applyStimulus(SW, 1'b0, 1'b1, E_FETCH_GO, "sw_fetch");
    applyStimulus(SW, 1'b0, 1'b0, E_DECODE,   "sw_decode");
    applyStimulus(SW, 1'b0, 1'b0, E_MEMADR,   "sw_memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(SW, 1'b0, 1'b0, E_MEMWRITE, "sw_memwrite_wait");
    applyStimulus(SW, 1'b0, 1'b1, E_MEMWRITE, "sw_memwrite_done");

    // beq taken then not taken
    applyStimulus(BEQ, 1'b1, 1'b1, E_FETCH_GO,  "beq1_fetch");
    applyStimulus(BEQ, 1'b1, 1'b1, E_DECODE,    "beq1_decode");
    applyStimulus(BEQ, 1'b1, 1'b1, E_BEQ_TAKEN, "beq_taken");
    applyStimulus(BEQ, 1'b0, 1'b1, E_FETCH_GO,  "beq0_fetch");
    applyStimulus(BEQ, 1'b0, 1'b1, E_DECODE,    "beq0_decode");
    applyStimulus(BEQ, 1'b0, 1'b1, E_BEQ_NOT,   "beq_not_taken");

    // FETCH stalled two cycles, then R-type
    applyStimulus(RTYP, 1'b0, 1'b0, E_FETCH_WAIT, "fetch_wait1");
    applyStimulus(RTYP, 1'b0, 1'b0, E_FETCH_WAIT, "fetch_wait2");
    applyStimulus(RTYP, 1'b0, 1'b1, E_FETCH_GO,   "r_fetch");
    applyStimulus(RTYP, 1'b0, 1'b1, E_DECODE,     "r_decode");
    applyStimulus(RTYP, 1'b0, 1'b1, E_EXECR,      "r_execr");
    applyStimulus(RTYP, 1'b0, 1'b1, E_ALUWB,      "r_aluwb");

    // I-type ALU
    applyStimulus(IALU, 1'b1, 1'b1, E_FETCH_GO, "i_fetch");
    applyStimulus(IALU, 1'b1, 1'b1, E_DECODE,   "i_decode");
    applyStimulus(IALU, 1'b1, 1'b1, E_EXECI,    "i_execi");
    applyStimulus(IALU, 1'b1, 1'b0, E_ALUWB,    "i_aluwb");

    // jal
    applyStimulus(JAL, 1'b0, 1'b1, E_FETCH_GO, "jal_fetch");
    applyStimulus(JAL, 1'b0, 1'b1, E_DECODE,   "jal_decode");
    applyStimulus(JAL, 1'b0, 1'b0, E_JAL,      "jal_jal");
    applyStimulus(JAL, 1'b0, 1'b1, E_ALUWB,    "jal_aluwb");

    // lw with one stalled MEMREAD cycle
    applyStimulus(LW, 1'b0, 1'b1, E_FETCH_GO, "lw2_fetch");
    applyStimulus(LW, 1'b0, 1'b1, E_DECODE,   "lw2_decode");
    applyStimulus(LW, 1'b0, 1'b1, E_MEMADR,   "lw2_memadr");
    applyStimulus(LW, 1'b0, 1'b0, E_MEMREAD,  "lw2_memread_wait");
    applyStimulus(LW, 1'b0, 1'b1, E_MEMREAD,  "lw2_memread_done");
    applyStimulus(LW, 1'b0, 1'b0, E_MEMWB,    "lw2_memwb");

    // illegal opcode: trapped until reset
    applyStimulus(BAD, 1'b0, 1'b1, E_FETCH_GO, "ill_fetch");
    applyStimulus(BAD, 1'b0, 1'b1, E_DECODE,   "ill_decode");
    for (int i = 0; i < 10; i++)
      applyStimulus(LW, 1'b1, i[0], E_ILLEGAL, "ill_hold");

    // asynchronous reset asserted mid-cycle from ILLEGAL
    #2;
    rst = 1'b1;
    item.exp  = E_FETCH_WAIT;
    item.name = "async_rst";
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    applyStimulus(LW, 1'b1, 1'b1, E_FETCH_WAIT, "rst_hold");
    rst = 1'b0;
    applyStimulus(LW, 1'b0, 1'b1, E_FETCH_GO, "post_rst_fetch");
    applyStimulus(LW, 1'b0, 1'b1, E_DECODE,   "post_rst_decode");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
